// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN weight-stationary systolic array: weight load, skewed feed, drain.
// Optional completed-run counter enabled by SYSTOLIC_SEQ_PERF_CNT_EN.
module systolic_seq_ctrl #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             weight_load_en,
  output logic [CNT_W-1:0] weight_row_sel,
  output logic             acc_clr,
  output logic             feed_en,
  output logic [CNT_W-1:0] feed_cnt,
  output logic             drain_en,
  output logic [CNT_W-1:0] drain_row,
  output logic [15:0]      run_count
);

  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_FEED = CNT_W'(2 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             busy_d, done_d, wl_en_d, acc_clr_d, feed_en_d, drain_en_d;
  logic [CNT_W-1:0] wl_row_d, feed_cnt_d, drain_row_d;

  // State and shared phase counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, plus output decode of the next state so outputs can be registered
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wl_en_d     = 1'b0;
    wl_row_d    = '0;
    acc_clr_d   = 1'b0;
    feed_en_d   = 1'b0;
    feed_cnt_d  = '0;
    drain_en_d  = 1'b0;
    drain_row_d = '0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_LOAD_W;
          cnt_nxt   = '0;
        end
      end
      S_LOAD_W: begin
        if (cnt == LAST_ROW) begin
          state_nxt = S_FEED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_FEED: begin
        if (cnt == LAST_FEED) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_ROW) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Abort overrides any phase progress
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end

    case (state_nxt)
      S_LOAD_W: begin
        busy_d   = 1'b1;
        wl_en_d  = 1'b1;
        wl_row_d = cnt_nxt;
      end
      S_FEED: begin
        busy_d     = 1'b1;
        feed_en_d  = 1'b1;
        feed_cnt_d = cnt_nxt;
        acc_clr_d  = (cnt_nxt == '0);
      end
      S_DRAIN: begin
        busy_d      = 1'b1;
        drain_en_d  = 1'b1;
        drain_row_d = cnt_nxt;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs; they track the registered state one-for-one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      weight_load_en <= 1'b0;
      weight_row_sel <= '0;
      acc_clr        <= 1'b0;
      feed_en        <= 1'b0;
      feed_cnt       <= '0;
      drain_en       <= 1'b0;
      drain_row      <= '0;
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      weight_load_en <= wl_en_d;
      weight_row_sel <= wl_row_d;
      acc_clr        <= acc_clr_d;
      feed_en        <= feed_en_d;
      feed_cnt       <= feed_cnt_d;
      drain_en       <= drain_en_d;
      drain_row      <= drain_row_d;
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [15:0] run_cnt_q;

  // Counts DONE cycles; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt_q <= 16'h0;
    end else if (state == S_DONE) begin
      run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign run_count = run_cnt_q;
`else
  assign run_count = 16'h0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized and directed bench for systolic_seq_ctrl (N=4) against a run-position model.
// Honours SYSTOLIC_SEQ_PERF_CNT_EN when defined for the build.
module tb_systolic_seq_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 6;
  localparam int          RUNLEN = 4 * N;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  localparam int          RC_STEP = 1;
`else
  localparam int          RC_STEP = 0;
`endif

  logic             clk = 1'b0;
  logic             rstn, start, abort;
  logic             busy, done, weight_load_en, acc_clr, feed_en, drain_en;
  logic [CNT_W-1:0] weight_row_sel, feed_cnt, drain_row;
  logic [15:0]      run_count;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model: p = position within a run (0 idle, 1..4N run cycle index)
  int          p    = 0;
  logic [15:0] rc_m = 16'h0;

  systolic_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .weight_load_en(weight_load_en), .weight_row_sel(weight_row_sel),
    .acc_clr(acc_clr), .feed_en(feed_en), .feed_cnt(feed_cnt),
    .drain_en(drain_en), .drain_row(drain_row), .run_count(run_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fld(input string name, input int act, input int exp, inout bit bad);
    if (act != exp) begin
      bad = 1'b1;
      miscompares++;
      $display("FAIL model.%s: got %0d expected %0d (p=%0d) at %0t", name, act, exp, p, $time);
    end
  endtask

  // Model update and per-cycle comparison
  always @(posedge clk or negedge rstn) begin
    bit bad;
    bit wl, fe, de;
    if (!rstn) begin
      p    = 0;
      rc_m = 16'h0;
    end else begin
      if (p == RUNLEN && RC_STEP == 1) rc_m = rc_m + 16'd1;
      if (p == 0)                        p = (start && !abort) ? 1 : 0;
      else if (abort || p == RUNLEN)     p = 0;
      else                               p = p + 1;
    end
    #1;
    if (chk_on) begin
      bad = 1'b0;
      wl = (p >= 1) && (p <= N);
      fe = (p >= N + 1) && (p <= 3 * N - 1);
      de = (p >= 3 * N) && (p <= 4 * N - 1);
      vectors++;
      fld("busy",    int'(busy),           int'(p != 0), bad);
      fld("done",    int'(done),           int'(p == RUNLEN), bad);
      fld("wl_en",   int'(weight_load_en), int'(wl), bad);
      fld("wl_row",  int'(weight_row_sel), wl ? p - 1 : 0, bad);
      fld("feed_en", int'(feed_en),        int'(fe), bad);
      fld("feed_cnt",int'(feed_cnt),       fe ? p - N - 1 : 0, bad);
      fld("acc_clr", int'(acc_clr),        int'(p == N + 1), bad);
      fld("drain_en",int'(drain_en),       int'(de), bad);
      fld("drain_row",int'(drain_row),     de ? p - 3 * N : 0, bad);
      fld("run_count",int'(run_count),     int'(rc_m), bad);
    end
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk_on = 1'b1;

    // Idle after reset
    repeat (10) @(negedge clk);
    chk("idle.busy", int'(busy), 0);
    chk("idle.done", int'(done), 0);
    chk("idle.run_count", int'(run_count), 0);

    // Single run with literal timing
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      case (c)
        1:  begin chk("run.c1.wl_en", int'(weight_load_en), 1); chk("run.c1.row", int'(weight_row_sel), 0); end
        4:  chk("run.c4.row", int'(weight_row_sel), 3);
        5:  begin chk("run.c5.acc_clr", int'(acc_clr), 1); chk("run.c5.feed_cnt", int'(feed_cnt), 0); end
        6:  chk("run.c6.acc_clr", int'(acc_clr), 0);
        11: chk("run.c11.feed_cnt", int'(feed_cnt), 6);
        12: begin chk("run.c12.drain_en", int'(drain_en), 1); chk("run.c12.feed_en", int'(feed_en), 0); end
        15: chk("run.c15.drain_row", int'(drain_row), 3);
        16: begin chk("run.c16.done", int'(done), 1); chk("run.c16.busy", int'(busy), 1); end
        17: begin chk("run.c17.busy", int'(busy), 0); chk("run.c17.done", int'(done), 0);
                  chk("run.c17.run_count", int'(run_count), RC_STEP); end
        default: ;
      endcase
    end
    repeat (3) @(negedge clk);

    // Abort in FEED
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 7) begin
        chk("abort.c7.feed_cnt", int'(feed_cnt), 2);
        abort = 1'b1;
      end
      if (c == 8) begin
        abort = 1'b0;
        chk("abort.c8.busy", int'(busy), 0);
        chk("abort.c8.feed_en", int'(feed_en), 0);
      end
      if (c == 10) chk("abort.run_count", int'(run_count), RC_STEP);
    end

    // Start held continuously
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      case (c)
        16: chk("held.c16.done", int'(done), 1);
        17: chk("held.c17.busy", int'(busy), 0);
        18: chk("held.c18.wl_en", int'(weight_load_en), 1);
        33: chk("held.c33.done", int'(done), 1);
        default: ;
      endcase
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset asserted in DRAIN, then a fresh run
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rstn = 1'b0;
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.drain_en", int'(drain_en), 0);
    @(negedge clk);
    rstn = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) chk("rst.c15.done", int'(done), 0);
      if (c == 16) chk("rst.c16.done", int'(done), 1);
    end
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 699) == 0) begin
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
